// File: rtl/relin_key_tile_fetcher.sv
// rtl/relin_key_tile_fetcher.sv - fetches fixed-width relinearisation key tiles from a fixed-latency key memory
module relin_key_tile_fetcher #(
    parameter int RELIN_KEY_TILE_WIDTH = 8,
    parameter int RELIN_KEY_LENGTH     = 64,
    parameter int COEFF_WIDTH          = 32,
    parameter int MEM_LATENCY          = 2
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         enable,
    output logic                                         request_signal,
    input  logic                                         addr_valid,
    input  logic [$clog2(RELIN_KEY_LENGTH):0]            addr_in,
    output logic                                         mem_rd_en,
    output logic [$clog2(RELIN_KEY_LENGTH)-1:0]          mem_rd_addr,
    input  logic [COEFF_WIDTH-1:0]                       mem_rd_data,
    output logic                                         tile_valid,
    input  logic                                         tile_ready,
    output logic [RELIN_KEY_TILE_WIDTH*COEFF_WIDTH-1:0]  tile_data,
    output logic [$clog2(RELIN_KEY_LENGTH):0]            tile_base,
    output logic                                         tile_last,
    output logic                                         addr_err
);

    localparam int AW   = $clog2(RELIN_KEY_LENGTH);
    localparam int BW   = AW + 1;
    localparam int CNTW = $clog2(RELIN_KEY_TILE_WIDTH) + 1;

    // Highest legal tile base; any base must also be tile-aligned.
    localparam logic [BW-1:0]   MAX_BASE   = BW'(RELIN_KEY_LENGTH - RELIN_KEY_TILE_WIDTH);
    localparam logic [BW-1:0]   ALIGN_MASK = BW'(RELIN_KEY_TILE_WIDTH - 1);
    localparam logic [CNTW-1:0] LAST_IDX   = CNTW'(RELIN_KEY_TILE_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT_ADDR,
        FETCH,
        COLLECT,
        HOLD
    } state_t;

    state_t                r_state;
    state_t                w_next_state;
    logic [1:0]            r_arm;
    logic [CNTW-1:0]       r_fetch_cnt;
    logic [CNTW-1:0]       r_ret_cnt;
    logic [MEM_LATENCY-1:0] r_lat_sr;
    logic [COEFF_WIDTH-1:0] r_words [RELIN_KEY_TILE_WIDTH];
    logic [BW-1:0]         r_tile_base;
    logic                  r_tile_last;
    logic                  r_addr_err;

    logic                  w_addr_legal;
    logic                  w_capture;
    logic                  w_ret_valid;
    logic                  w_ret_last;

    assign w_addr_legal = (addr_in <= MAX_BASE) && ((addr_in & ALIGN_MASK) == '0);
    assign w_capture    = (r_state == WAIT_ADDR) && addr_valid;
    assign w_ret_valid  = r_lat_sr[MEM_LATENCY-1];
    assign w_ret_last   = w_ret_valid && (r_ret_cnt == LAST_IDX);

    assign tile_base = r_tile_base;
    assign tile_last = r_tile_last;
    assign addr_err  = r_addr_err;

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and state-derived strobes.
    always_comb begin
        w_next_state   = r_state;
        request_signal = 1'b0;
        mem_rd_en      = 1'b0;
        mem_rd_addr    = '0;
        tile_valid     = 1'b0;
        case (r_state)
            IDLE: begin
                if (enable && r_arm[1]) begin
                    w_next_state = REQ;
                end
            end
            REQ: begin
                request_signal = 1'b1;
                w_next_state   = WAIT_ADDR;
            end
            WAIT_ADDR: begin
                if (addr_valid) begin
                    w_next_state = w_addr_legal ? FETCH : IDLE;
                end
            end
            FETCH: begin
                mem_rd_en   = 1'b1;
                mem_rd_addr = r_tile_base[AW-1:0] + AW'(r_fetch_cnt);
                if (r_fetch_cnt == LAST_IDX) begin
                    w_next_state = COLLECT;
                end
            end
            COLLECT: begin
                if (w_ret_last) begin
                    w_next_state = HOLD;
                end
            end
            HOLD: begin
                tile_valid = 1'b1;
                if (tile_ready) begin
                    w_next_state = enable ? REQ : IDLE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Two-cycle arming delay so the first request never follows reset release too closely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_arm <= 2'b00;
        end else begin
            r_arm <= {r_arm[0], 1'b1};
        end
    end

    // Issue counter: walks the word offsets of the tile while in FETCH.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_cnt <= '0;
        end else if (r_state == FETCH && r_fetch_cnt != LAST_IDX) begin
            r_fetch_cnt <= r_fetch_cnt + 1'b1;
        end else begin
            r_fetch_cnt <= '0;
        end
    end

    // Read-latency tracker: a set bit reaching the end marks a returning word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_lat_sr <= '0;
        end else begin
            r_lat_sr[0] <= mem_rd_en;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                r_lat_sr[i] <= r_lat_sr[i-1];
            end
        end
    end

    // Return counter: selects the slot for each returning word, rearmed per tile.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ret_cnt <= '0;
        end else if (r_state == WAIT_ADDR) begin
            r_ret_cnt <= '0;
        end else if (w_ret_valid) begin
            r_ret_cnt <= r_ret_cnt + 1'b1;
        end
    end

    // Tile slot storage; returns land in issue order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < RELIN_KEY_TILE_WIDTH; k++) begin
                r_words[k] <= '0;
            end
        end else begin
            for (int k = 0; k < RELIN_KEY_TILE_WIDTH; k++) begin
                if (w_ret_valid && r_ret_cnt == CNTW'(k)) begin
                    r_words[k] <= mem_rd_data;
                end
            end
        end
    end

    // Flatten the slots onto the tile output bus.
    always_comb begin
        tile_data = '0;
        for (int k = 0; k < RELIN_KEY_TILE_WIDTH; k++) begin
            tile_data[k*COEFF_WIDTH +: COEFF_WIDTH] = r_words[k];
        end
    end

    // Base capture, last-tile flag and sticky illegal-base flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_tile_base <= '0;
            r_tile_last <= 1'b0;
            r_addr_err  <= 1'b0;
        end else if (w_capture) begin
            r_tile_base <= addr_in;
            r_tile_last <= (addr_in == MAX_BASE);
            if (!w_addr_legal) begin
                r_addr_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_relin_key_tile_fetcher.sv
// tb/tb_relin_key_tile_fetcher.sv - randomized self-checking bench for relin_key_tile_fetcher
module tb_relin_key_tile_fetcher;

    localparam int W   = 8;
    localparam int LEN = 64;
    localparam int CWD = 32;
    localparam int L   = 2;
    localparam int AW  = $clog2(LEN);
    localparam int BW  = AW + 1;
    localparam int TDW = W * CWD;

    logic           clk;
    logic           reset;
    logic           enable;
    logic           request_signal;
    logic           addr_valid;
    logic [BW-1:0]  addr_in;
    logic           mem_rd_en;
    logic [AW-1:0]  mem_rd_addr;
    logic [CWD-1:0] mem_rd_data;
    logic           tile_valid;
    logic           tile_ready;
    logic [TDW-1:0] tile_data;
    logic [BW-1:0]  tile_base;
    logic           tile_last;
    logic           addr_err;

    relin_key_tile_fetcher #(
        .RELIN_KEY_TILE_WIDTH (W),
        .RELIN_KEY_LENGTH     (LEN),
        .COEFF_WIDTH          (CWD),
        .MEM_LATENCY          (L)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .request_signal (request_signal),
        .addr_valid     (addr_valid),
        .addr_in        (addr_in),
        .mem_rd_en      (mem_rd_en),
        .mem_rd_addr    (mem_rd_addr),
        .mem_rd_data    (mem_rd_data),
        .tile_valid     (tile_valid),
        .tile_ready     (tile_ready),
        .tile_data      (tile_data),
        .tile_base      (tile_base),
        .tile_last      (tile_last),
        .addr_err       (addr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int rel_cyc  = -1;
    logic model_err = 1'b0;
    int rd_q [$];

    logic [CWD-1:0] mem [LEN];
    logic [CWD-1:0] dpipe [L];
    logic           vpipe [L];

    always @(posedge clk) cyc <= cyc + 1;

    // Key memory: data is captured at issue time and presented exactly L cycles later.
    always @(posedge clk) begin
        vpipe[0] <= mem_rd_en;
        dpipe[0] <= mem[mem_rd_addr];
        for (int i = 1; i < L; i++) begin
            vpipe[i] <= vpipe[i-1];
            dpipe[i] <= dpipe[i-1];
        end
    end
    assign mem_rd_data = vpipe[L-1] ? dpipe[L-1] : CWD'(32'hDEADBEEF);

    always @(negedge clk) if (mem_rd_en) rd_q.push_back(int'(mem_rd_addr));

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_req"},   request_signal, 0);
        check_eq({tag, "_rden"},  mem_rd_en, 0);
        check_eq({tag, "_rdadr"}, mem_rd_addr, 0);
        check_eq({tag, "_valid"}, tile_valid, 0);
        check_eq({tag, "_data"},  tile_data, 0);
        check_eq({tag, "_base"},  tile_base, 0);
        check_eq({tag, "_last"},  tile_last, 0);
        check_eq({tag, "_err"},   addr_err, 0);
    endtask

    task automatic wait_req(output int ok);
        ok = 0;
        for (int i = 0; i < 64 && ok == 0; i++) begin
            @(negedge clk);
            if (request_signal === 1'b1) ok = 1;
        end
    endtask

    function automatic logic base_legal(input int base);
        return (base <= LEN - W) && (base % W == 0);
    endfunction

    task automatic run_tile(input int base, input int hold);
        int ok;
        int t0;
        int n;
        logic legal;
        logic [TDW-1:0] exp_tile;
        wait_req(ok);
        check_eq("req_seen", ok, 1);
        if (ok == 0) return;
        if (rel_cyc >= 0) begin
            check_eq("req_after_reset_ge2", (cyc - rel_cyc) >= 2, 1);
            rel_cyc = -1;
        end
        t0 = cyc;
        rd_q.delete();
        legal = base_legal(base);
        @(posedge clk); #1;
        addr_valid = 1'b1;
        addr_in    = BW'(base);
        tile_ready = (hold == 0);
        if (!legal) enable = 1'b0;
        @(posedge clk); #1;
        addr_valid = 1'b0;
        addr_in    = BW'($urandom);
        if (!legal) begin
            model_err = 1'b1;
            for (int i = 0; i < 6; i++) begin
                @(negedge clk);
                check_eq("bad_no_rden", mem_rd_en, 0);
                check_eq("bad_no_req", request_signal, 0);
                check_eq("bad_no_valid", tile_valid, 0);
            end
            check_eq("bad_addr_err", addr_err, 1);
            enable = 1'b1;
            return;
        end
        n = 0;
        while (tile_valid !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("valid_seen", tile_valid, 1);
        if (tile_valid !== 1'b1) return;
        check_eq("valid_latency", cyc - t0, W + L + 2);
        check_eq("rd_count", rd_q.size(), W);
        for (int k = 0; k < W && k < rd_q.size(); k++) check_eq("rd_addr", rd_q[k], base + k);
        for (int k = 0; k < W; k++) exp_tile[k*CWD +: CWD] = mem[(base + k) % LEN];
        check_eq("tile_data", tile_data, exp_tile);
        check_eq("tile_base", tile_base, base);
        check_eq("tile_last", tile_last, base == LEN - W);
        check_eq("addr_err_sticky", addr_err, model_err);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check_eq("hold_valid", tile_valid, 1);
            check_eq("hold_data", tile_data, exp_tile);
            check_eq("hold_base", tile_base, base);
            check_eq("hold_quiet", {request_signal, mem_rd_en}, 0);
        end
        if (hold > 0) begin
            @(posedge clk); #1;
            tile_ready = 1'b1;
            @(posedge clk); #1;
            tile_ready = 1'b0;
        end else begin
            @(posedge clk); #1;
        end
        check_eq("valid_drop", tile_valid, 0);
    endtask

    initial begin
        int ok;
        int n;
        int base;
        reset      = 1'b0;
        enable     = 1'b0;
        addr_valid = 1'b0;
        addr_in    = '0;
        tile_ready = 1'b0;
        for (int i = 0; i < LEN; i++) mem[i] = CWD'(i);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_all_zero("rst");
        enable = 1'b1;
        @(posedge clk); #1;
        reset   = 1'b1;
        rel_cyc = cyc;

        // Identity memory, base 0, then a continuous sweep wrapping back to 0.
        run_tile(0, 0);
        for (int t = 1; t <= LEN / W; t++) run_tile((t * W) % LEN, 0);

        for (int i = 0; i < LEN; i++) mem[i] = $urandom;
        run_tile($urandom_range(0, LEN / W - 1) * W, 20);

        run_tile(60, 0);
        run_tile(5, 0);

        // Reset three reads into a fetch; stale returns must not reach the next tile.
        tile_ready = 1'b0;
        wait_req(ok);
        check_eq("rst_req_seen", ok, 1);
        rd_q.delete();
        @(posedge clk); #1;
        addr_valid = 1'b1;
        addr_in    = BW'(16);
        @(posedge clk); #1;
        addr_valid = 1'b0;
        n = 0;
        while (rd_q.size() < 3 && n < 50) begin
            @(negedge clk); #1;
            n++;
        end
        check_eq("rst_three_reads", rd_q.size(), 3);
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("midrst_quiet", {request_signal, mem_rd_en, tile_valid}, 0);
        end
        for (int i = 0; i < LEN; i++) mem[i] = $urandom;
        model_err = 1'b0;
        @(posedge clk); #1;
        reset   = 1'b1;
        rel_cyc = cyc;
        run_tile(16, 1);

        for (int r = 0; r < 12; r++) begin
            if ($urandom_range(0, 4) == 0) base = $urandom_range(0, 2 * LEN - 1);
            else base = $urandom_range(0, LEN / W - 1) * W;
            run_tile(base, $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
